// File: rtl/codif_escritura_rtc.sv
// codif_escritura_rtc: write-sequence encoder for the RTC multiplexed
// address/data bus. One start request emits an init burst, a register write
// (binary field value converted to packed BCD by sequential double-dabble)
// or a read command, as a stream of bus words under a valid/ready handshake.
//
// Ports:
//   clk, reset      clock (rising edge), asynchronous active-low reset
//   inicio          start pulse, sampled only while idle
//   modo[1:0]       00 init, 01 write, 10 read command, 11 reserved
//   dir[Y-1:0]      register address for write/read
//   dato[N-1:0]     binary field value for write
//   salida[Y-1:0]   bus word
//   a_d             0 = address word, 1 = data word
//   salida_valid    salida/a_d valid
//   bus_ready       downstream accepts the word at posedge when valid&ready
//   ocupado         busy from the cycle after acceptance until done
//   hecho           one-cycle pulse after the last word is accepted
//   err             one-cycle pulse: reserved modo or dato > MAXV
module codif_escritura_rtc #(
  parameter int unsigned N        = 6,
  parameter int unsigned DIG      = 2,
  parameter int unsigned Y        = 8,
  parameter int unsigned MAXV     = 59,
  parameter int unsigned INIT_LEN = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inicio,
  input  logic [1:0]   modo,
  input  logic [Y-1:0] dir,
  input  logic [N-1:0] dato,
  output logic [Y-1:0] salida,
  output logic         a_d,
  output logic         salida_valid,
  input  logic         bus_ready,
  output logic         ocupado,
  output logic         hecho,
  output logic         err
);

  localparam int unsigned BW = 4 * DIG;
  localparam int unsigned CW = $clog2(N + 1);
  localparam int unsigned IW = 2;

  localparam logic [1:0] M_INIT  = 2'b00;
  localparam logic [1:0] M_WRITE = 2'b01;
  localparam logic [1:0] M_READ  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONV,
    S_ADDR,
    S_DATA,
    S_DONE
  } state_t;

  state_t          state_q;
  logic [1:0]      modo_q;
  logic [Y-1:0]    dir_q;
  logic [N-1:0]    dato_q;
  logic [N-1:0]    bin_q;
  logic [BW-1:0]   bcd_q;
  logic [CW-1:0]   cnt_q;
  logic [IW-1:0]   idx_q;
  logic [Y-1:0]    salida_q;
  logic            a_d_q;
  logic            valid_q;
  logic            ocupado_q;
  logic            hecho_q;
  logic            err_q;

  logic [BW-1:0]   bcd_adj;
  logic [BW-1:0]   bcd_d;
  logic [N-1:0]    bin_d;
  logic            fuera_rango;
  logic            acepta;

  // Init burst address table
  function automatic logic [Y-1:0] init_addr(input logic [IW-1:0] i);
    case (i)
      2'd0:    init_addr = Y'(8'h02);
      2'd1:    init_addr = Y'(8'h02);
      default: init_addr = Y'(8'h10);
    endcase
  endfunction

  // Init burst data table
  function automatic logic [Y-1:0] init_data(input logic [IW-1:0] i);
    case (i)
      2'd0:    init_data = Y'(8'h10);
      2'd1:    init_data = Y'(8'h00);
      default: init_data = Y'(8'hD2);
    endcase
  endfunction

  // One double-dabble step: add 3 to every digit >= 5, then shift left by one
  always_comb begin
    bcd_adj = bcd_q;
    for (int k = 0; k < int'(DIG); k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) begin
        bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
      end
    end
    {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
  end

  assign fuera_rango = (32'(dato_q) > MAXV);
  assign acepta      = valid_q & bus_ready;

  // Sequencer; outputs are loaded on the same edge as the state they belong to
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      modo_q    <= '0;
      dir_q     <= '0;
      dato_q    <= '0;
      bin_q     <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      salida_q  <= '0;
      a_d_q     <= 1'b0;
      valid_q   <= 1'b0;
      ocupado_q <= 1'b0;
      hecho_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      hecho_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (inicio) begin
            modo_q <= modo;
            dir_q  <= dir;
            dato_q <= dato;
            case (modo)
              M_WRITE: begin
                state_q   <= S_CONV;
                bin_q     <= dato;
                bcd_q     <= '0;
                cnt_q     <= '0;
                ocupado_q <= 1'b1;
              end
              M_INIT: begin
                state_q   <= S_ADDR;
                idx_q     <= '0;
                salida_q  <= init_addr(IW'(0));
                a_d_q     <= 1'b0;
                valid_q   <= 1'b1;
                ocupado_q <= 1'b1;
              end
              M_READ: begin
                state_q   <= S_ADDR;
                salida_q  <= dir;
                a_d_q     <= 1'b0;
                valid_q   <= 1'b1;
                ocupado_q <= 1'b1;
              end
              default: err_q <= 1'b1;
            endcase
          end
        end

        // N shift cycles, then one exit cycle that presents the address word
        S_CONV: begin
          if (cnt_q < CW'(N)) begin
            bcd_q <= bcd_d;
            bin_q <= bin_d;
            cnt_q <= cnt_q + CW'(1);
          end else begin
            if (fuera_rango) begin
              bcd_q <= '0;
              err_q <= 1'b1;
            end
            state_q  <= S_ADDR;
            salida_q <= dir_q;
            a_d_q    <= 1'b0;
            valid_q  <= 1'b1;
          end
        end

        S_ADDR: begin
          if (acepta) begin
            case (modo_q)
              M_WRITE: begin
                state_q  <= S_DATA;
                salida_q <= Y'(bcd_q);
                a_d_q    <= 1'b1;
              end
              M_INIT: begin
                state_q  <= S_DATA;
                salida_q <= init_data(idx_q);
                a_d_q    <= 1'b1;
              end
              default: begin
                state_q   <= S_DONE;
                salida_q  <= '0;
                a_d_q     <= 1'b0;
                valid_q   <= 1'b0;
                ocupado_q <= 1'b0;
                hecho_q   <= 1'b1;
              end
            endcase
          end
        end

        S_DATA: begin
          if (acepta) begin
            if (modo_q == M_INIT && idx_q < IW'(INIT_LEN - 1)) begin
              state_q  <= S_ADDR;
              idx_q    <= idx_q + IW'(1);
              salida_q <= init_addr(idx_q + IW'(1));
              a_d_q    <= 1'b0;
            end else begin
              state_q   <= S_DONE;
              salida_q  <= '0;
              a_d_q     <= 1'b0;
              valid_q   <= 1'b0;
              ocupado_q <= 1'b0;
              hecho_q   <= 1'b1;
            end
          end
        end

        S_DONE: state_q <= S_IDLE;

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign salida       = salida_q;
  assign a_d          = a_d_q;
  assign salida_valid = valid_q;
  assign ocupado      = ocupado_q;
  assign hecho        = hecho_q;
  assign err          = err_q;

endmodule
